// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- registered, multi-cycle keypad-calculator ALU
//
// Sits between the keypad decode/operand registers and the display formatter.
// Keeps an internal carry/borrow flag so chained ADC/SBC ops need no external
// carry loop, and adds an unsigned shift-add multiply (one step per cycle).
//
// Parameters:
//   WIDTH          operand / result width in bits (min 2)
//
// Ports:
//   IN_clk         system clock, rising edge
//   IN_rst         asynchronous, active-high reset
//   IN_start       request strobe
//   IN_op          opcode, sampled at accept
//   IN_data_a      operand A, sampled at accept
//   IN_data_b      operand B, sampled at accept
//   OUT_S          result (low half for MUL)
//   OUT_S_hi       MUL high half, 0 for every other op
//   OUT_zero       zero flag
//   OUT_carry_out  carry flag; carry/borrow source for ADC/SBC
//   OUT_busy       multiply in progress
//   OUT_done       one-cycle pulse when results update
//   OUT_err        one-cycle pulse on an illegal opcode
//   dbg_state      current FSM state (0 = IDLE, 1 = MUL)
//
// Handshake: a request is accepted on a rising edge where IN_start=1 and
// OUT_busy=0 (OUT_busy acts as the inverse of ready). Requests presented while
// OUT_busy=1 are dropped, not queued. The edge that completes a MUL is never
// an accept edge; the next accept can happen on the following edge.
//
// Opcodes: A ADD, B SUB, C AND, D OR, E CMP, 1 ADC, 2 SBC, 3 MUL; others illegal.
//
// Optional build macro: ALU_SAT_EN -- ADD/ADC clamp to all-ones on carry,
// SUB/SBC clamp to zero on borrow. The carry flag still reports the raw
// carry/borrow and the zero flag follows the clamped result.
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             IN_clk,
    input  logic             IN_rst,
    input  logic             IN_start,
    input  logic [3:0]       IN_op,
    input  logic [WIDTH-1:0] IN_data_a,
    input  logic [WIDTH-1:0] IN_data_b,
    output logic [WIDTH-1:0] OUT_S,
    output logic [WIDTH-1:0] OUT_S_hi,
    output logic             OUT_zero,
    output logic             OUT_carry_out,
    output logic             OUT_busy,
    output logic             OUT_done,
    output logic             OUT_err,
    output logic             dbg_state
);

    localparam logic [3:0] OP_ADD = 4'hA;
    localparam logic [3:0] OP_SUB = 4'hB;
    localparam logic [3:0] OP_AND = 4'hC;
    localparam logic [3:0] OP_OR  = 4'hD;
    localparam logic [3:0] OP_CMP = 4'hE;
    localparam logic [3:0] OP_ADC = 4'h1;
    localparam logic [3:0] OP_SBC = 4'h2;
    localparam logic [3:0] OP_MUL = 4'h3;

    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t             state_q, state_n;
    logic [WIDTH-1:0]   s_q, s_n;
    logic [WIDTH-1:0]   s_hi_q, s_hi_n;
    logic               zero_q, zero_n;
    logic               carry_q, carry_n;
    logic               done_q, done_n;
    logic               err_q, err_n;
    logic [WIDTH-1:0]   mul_a_q, mul_a_n;
    logic [WIDTH-1:0]   mul_hi_q, mul_hi_n;
    logic [WIDTH-1:0]   mul_lo_q, mul_lo_n;
    logic [CW-1:0]      cnt_q, cnt_n;

    // Single-cycle ALU results (combinational, from the live inputs)
    logic               adc_cin;
    logic               sbc_bin;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH-1:0]   alu_s;
    logic               alu_c;
    logic               alu_z;
    logic               alu_legal;
    logic               alu_is_mul;

    // One shift-add step
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;

    // Only ADC/SBC consume the stored flag; ADD/SUB/CMP run with no carry/borrow in.
    assign adc_cin = (IN_op == OP_ADC) ? carry_q  : 1'b0;
    assign sbc_bin = (IN_op == OP_SBC) ? ~carry_q : 1'b0;

    // The extra MSB is the carry out (add) or borrow (sub).
    assign add_w = {1'b0, IN_data_a} + {1'b0, IN_data_b} + {{WIDTH{1'b0}}, adc_cin};
    assign sub_w = {1'b0, IN_data_a} - {1'b0, IN_data_b} - {{WIDTH{1'b0}}, sbc_bin};

    always_comb begin
        alu_s      = '0;
        alu_c      = 1'b0;
        alu_z      = 1'b0;
        alu_legal  = 1'b1;
        alu_is_mul = 1'b0;
        unique case (IN_op)
            OP_ADD, OP_ADC: begin
                alu_s = add_w[WIDTH-1:0];
                alu_c = add_w[WIDTH];
`ifdef ALU_SAT_EN
                if (add_w[WIDTH]) alu_s = '1;
`endif
                alu_z = (alu_s == '0);
            end
            OP_SUB, OP_SBC: begin
                alu_s = sub_w[WIDTH-1:0];
                // Flag is "no borrow" for subtraction.
                alu_c = ~sub_w[WIDTH];
`ifdef ALU_SAT_EN
                if (sub_w[WIDTH]) alu_s = '0;
`endif
                alu_z = (alu_s == '0);
            end
            OP_AND: begin
                alu_s = IN_data_a & IN_data_b;
                alu_z = (alu_s == '0);
            end
            OP_OR: begin
                alu_s = IN_data_a | IN_data_b;
                alu_z = (alu_s == '0);
            end
            OP_CMP: begin
                // Unlike SUB, CMP flags a<b directly (the raw borrow).
                alu_s = sub_w[WIDTH-1:0];
                alu_c = sub_w[WIDTH];
                alu_z = (IN_data_a == IN_data_b);
            end
            OP_MUL: begin
                alu_is_mul = 1'b1;
            end
            default: begin
                alu_legal = 1'b0;
            end
        endcase
    end

    // LSB-first shift-add: the multiplier sits in the low half and is shifted
    // out as the partial product is shifted in from the top.
    assign mul_sum = {1'b0, mul_hi_q} + (mul_lo_q[0] ? {1'b0, mul_a_q} : '0);
    assign step_hi = mul_sum[WIDTH:1];
    assign step_lo = {mul_sum[0], mul_lo_q[WIDTH-1:1]};

    always_comb begin
        state_n  = state_q;
        s_n      = s_q;
        s_hi_n   = s_hi_q;
        zero_n   = zero_q;
        carry_n  = carry_q;
        done_n   = 1'b0;
        err_n    = 1'b0;
        mul_a_n  = mul_a_q;
        mul_hi_n = mul_hi_q;
        mul_lo_n = mul_lo_q;
        cnt_n    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (IN_start) begin
                    if (alu_is_mul) begin
                        // Visible results hold until the multiply completes.
                        mul_a_n  = IN_data_a;
                        mul_hi_n = '0;
                        mul_lo_n = IN_data_b;
                        cnt_n    = '0;
                        state_n  = MUL;
                    end else if (alu_legal) begin
                        s_n     = alu_s;
                        s_hi_n  = '0;
                        zero_n  = alu_z;
                        carry_n = alu_c;
                        done_n  = 1'b1;
                    end else begin
                        // Illegal op clears the result but leaves the flags alone.
                        s_n    = '0;
                        s_hi_n = '0;
                        err_n  = 1'b1;
                    end
                end
            end
            MUL: begin
                mul_hi_n = step_hi;
                mul_lo_n = step_lo;
                cnt_n    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    s_n     = step_lo;
                    s_hi_n  = step_hi;
                    carry_n = |step_hi;
                    zero_n  = ~|{step_hi, step_lo};
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge IN_clk or posedge IN_rst) begin
        if (IN_rst) begin
            state_q  <= IDLE;
            s_q      <= '0;
            s_hi_q   <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            mul_a_q  <= '0;
            mul_hi_q <= '0;
            mul_lo_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_n;
            s_q      <= s_n;
            s_hi_q   <= s_hi_n;
            zero_q   <= zero_n;
            carry_q  <= carry_n;
            done_q   <= done_n;
            err_q    <= err_n;
            mul_a_q  <= mul_a_n;
            mul_hi_q <= mul_hi_n;
            mul_lo_q <= mul_lo_n;
            cnt_q    <= cnt_n;
        end
    end

    assign OUT_S         = s_q;
    assign OUT_S_hi      = s_hi_q;
    assign OUT_zero      = zero_q;
    assign OUT_carry_out = carry_q;
    assign OUT_busy      = (state_q == MUL);
    assign OUT_done      = done_q;
    assign OUT_err       = err_q;
    assign dbg_state     = state_q;

endmodule
